// File: rtl/ps2_key_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_queue
// Brief    : Synchronizes PS/2 press/release strobes into an 8-deep event FIFO.
//            Optional macro PS2_MODIFIER_TRACK_EN adds the modifiers output.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_queue (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_downw,
    input  logic       key_upw,
    input  logic [7:0] key,
    output logic       evt_valid,
    output logic       evt_up,
    output logic [7:0] evt_code,
    input  logic       evt_ready,
    output logic [3:0] evt_count,
    output logic       overflow,
`ifdef PS2_MODIFIER_TRACK_EN
    output logic [3:0] modifiers,
`endif
    input  logic       ovf_clr
);

    localparam int unsigned c_DEPTH = 8;

    logic       r_dn_s1, r_dn_s2, r_dn_s3;
    logic       r_up_s1, r_up_s2, r_up_s3;
    logic [7:0] r_key_s1, r_key_s2;
    logic [1:0] r_settle;
    logic       r_dn_arm, r_up_arm;

    logic [8:0] r_mem [0:c_DEPTH-1];
    logic [2:0] r_wr_ptr, r_rd_ptr;
    logic [3:0] r_count;
    logic       r_ovf;

    logic       w_settled, w_dn_rise, w_up_rise;
    logic       w_push, w_pop, w_full, w_wr, w_drop;

    // Synchronizer chains; cleared by reset so in-flight edges are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dn_s1  <= 1'b0;
            r_dn_s2  <= 1'b0;
            r_dn_s3  <= 1'b0;
            r_up_s1  <= 1'b0;
            r_up_s2  <= 1'b0;
            r_up_s3  <= 1'b0;
            r_key_s1 <= 8'h00;
            r_key_s2 <= 8'h00;
        end else begin
            r_dn_s1  <= key_downw;
            r_dn_s2  <= r_dn_s1;
            r_dn_s3  <= r_dn_s2;
            r_up_s1  <= key_upw;
            r_up_s2  <= r_up_s1;
            r_up_s3  <= r_up_s2;
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
        end
    end

    // A strobe only counts once it has been seen low after the chain refilled,
    // so a strobe held across reset cannot masquerade as a fresh rising edge.
    assign w_settled = (r_settle == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle <= 2'd0;
            r_dn_arm <= 1'b0;
            r_up_arm <= 1'b0;
        end else begin
            if (!w_settled)
                r_settle <= r_settle + 2'd1;
            if (w_settled && !r_dn_s2)
                r_dn_arm <= 1'b1;
            if (w_settled && !r_up_s2)
                r_up_arm <= 1'b1;
        end
    end

    assign w_dn_rise = r_dn_s2 & ~r_dn_s3 & r_dn_arm;
    assign w_up_rise = r_up_s2 & ~r_up_s3 & r_up_arm;
    assign w_push    = w_dn_rise | w_up_rise;
    assign w_full    = (r_count == 4'(c_DEPTH));
    assign w_pop     = evt_valid & evt_ready;
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr && !reset)
            r_mem[r_wr_ptr] <= {w_up_rise, r_key_s2};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
            r_count  <= 4'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 3'd1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            // Set wins over a simultaneous clear.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign evt_valid = (r_count != 4'd0);
    assign evt_up    = evt_valid & r_mem[r_rd_ptr][8];
    assign evt_code  = evt_valid ? r_mem[r_rd_ptr][7:0] : 8'h00;
    assign evt_count = r_count;
    assign overflow  = r_ovf;

`ifdef PS2_MODIFIER_TRACK_EN
    logic [3:0] r_mod;

    // Tracks every detected event, including ones dropped by a full queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mod <= 4'b0000;
        end else if (w_push) begin
            case (r_key_s2)
                8'h12:   r_mod[0] <= ~w_up_rise;
                8'h59:   r_mod[1] <= ~w_up_rise;
                8'h14:   r_mod[2] <= ~w_up_rise;
                8'h11:   r_mod[3] <= ~w_up_rise;
                default: r_mod    <= r_mod;
            endcase
        end
    end

    assign modifiers = r_mod;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_event_queue
// Brief    : Scoreboard bench for ps2_key_event_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_downw, key_upw;
    logic [7:0] key;
    logic       evt_valid, evt_up, evt_ready;
    logic [7:0] evt_code;
    logic [3:0] evt_count;
    logic       overflow, ovf_clr;
`ifdef PS2_MODIFIER_TRACK_EN
    logic [3:0] modifiers;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int mcount   = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_head;

    always #5 clk = ~clk;

    ps2_key_event_queue u_dut (
        .clk       (clk),
        .reset     (reset),
        .key_downw (key_downw),
        .key_upw   (key_upw),
        .key       (key),
        .evt_valid (evt_valid),
        .evt_up    (evt_up),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .evt_count (evt_count),
        .overflow  (overflow),
`ifdef PS2_MODIFIER_TRACK_EN
        .modifiers (modifiers),
`endif
        .ovf_clr   (ovf_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one event; release wins when both strobes rise together.
    task automatic send_evt(input logic up, input logic dn, input logic [7:0] code);
        key       = code;
        key_downw = dn;
        key_upw   = up;
        repeat (4) tick();
        key_downw = 1'b0;
        key_upw   = 1'b0;
        repeat (4) tick();
        if (mcount < 8) begin
            sb.push_back({up, code});
            mcount++;
        end
    endtask

    task automatic pop_check(input string tag);
        int n = 0;
        while (!evt_valid && n < 20) begin
            tick();
            n++;
        end
        if (!evt_valid) begin
            check_eq({tag, "_wait"}, 32'(evt_valid), 32'd1);
        end else if (sb.size() == 0) begin
            check_eq({tag, "_unexpected"}, 32'(evt_valid), 32'd0);
        end else begin
            exp_head = sb.pop_front();
            check_eq(tag, {23'd0, evt_up, evt_code}, {23'd0, exp_head});
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
            mcount--;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; key_downw = 1'b0; key_upw = 1'b0; key = 8'h00;
        evt_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_count", 32'(evt_count), 32'd0);
        check_eq("rst_ovf",   32'(overflow),  32'd0);
        check_eq("rst_head",  {23'd0, evt_up, evt_code}, 32'd0);
`ifdef PS2_MODIFIER_TRACK_EN
        check_eq("rst_mod",   32'(modifiers), 32'd0);
`endif
        reset = 1'b0;
        repeat (5) tick();

        // Press latency: strobe sampled at edge 1, valid after edge 3.
        key = 8'h1C;
        key_downw = 1'b1;
        tick();
        tick();
        check_eq("press_early", 32'(evt_valid), 32'd0);
        tick();
        check_eq("press_valid", 32'(evt_valid), 32'd1);
        check_eq("press_head",  {23'd0, evt_up, evt_code}, {23'd0, 9'h01C});
        sb.push_back(9'h01C);
        mcount = 1;
        repeat (37) tick();
        key_downw = 1'b0;
        repeat (4) tick();
        check_eq("press_count", 32'(evt_count), 32'd1);

        send_evt(1'b1, 1'b0, 8'h1C);
        check_eq("rel_count", 32'(evt_count), 32'd2);
        evt_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_head = sb.pop_front();
            check_eq("rel_pop", {23'd0, evt_up, evt_code}, {23'd0, exp_head});
            tick();
        end
        evt_ready = 1'b0;
        mcount -= 2;
        check_eq("rel_empty", 32'(evt_count), 32'd0);

        send_evt(1'b1, 1'b1, 8'h2D);
        check_eq("simul_count", 32'(evt_count), 32'd1);
        pop_check("simul_head");
        check_eq("simul_empty", 32'(evt_count), 32'd0);

        for (int i = 1; i <= 9; i++)
            send_evt(1'b0, 1'b1, 8'(i));
        check_eq("ovf_count", 32'(evt_count), 32'd8);
        check_eq("ovf_flag",  32'(overflow),  32'd1);
        check_eq("ovf_head",  {23'd0, evt_up, evt_code}, 32'h001);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("ovf_clr", 32'(overflow), 32'd0);

        // Push of 0x0A lands on the same edge as a pop while full.
        key = 8'h0A;
        key_downw = 1'b1;
        tick();
        tick();
        check_eq("fpp_head", {23'd0, evt_up, evt_code}, {23'd0, sb[0]});
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        void'(sb.pop_front());
        sb.push_back(9'h00A);
        check_eq("fpp_count", 32'(evt_count), 32'd8);
        check_eq("fpp_ovf",   32'(overflow),  32'd0);
        key_downw = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++)
            pop_check("fpp_drain");
        check_eq("fpp_empty", 32'(evt_count), 32'd0);

        send_evt(1'b0, 1'b1, 8'h21);
        send_evt(1'b0, 1'b1, 8'h22);
        send_evt(1'b0, 1'b1, 8'h23);
        check_eq("mrst_q3", 32'(evt_count), 32'd3);
        key = 8'h24;
        key_downw = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        mcount = 0;
        check_eq("mrst_count", 32'(evt_count), 32'd0);
        check_eq("mrst_valid", 32'(evt_valid), 32'd0);
        repeat (20) tick();
        check_eq("mrst_held", 32'(evt_count), 32'd0);
        key_downw = 1'b0;
        repeat (4) tick();
        send_evt(1'b0, 1'b1, 8'h25);
        check_eq("mrst_new", 32'(evt_count), 32'd1);
        pop_check("mrst_head");

`ifdef PS2_MODIFIER_TRACK_EN
        send_evt(1'b0, 1'b1, 8'h12);
        check_eq("mod_press", 32'(modifiers), 32'd1);
        send_evt(1'b1, 1'b0, 8'h12);
        check_eq("mod_rel", 32'(modifiers), 32'd0);
        pop_check("mod_pop");
        pop_check("mod_pop");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
